program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time loader sitting directly upstream of the instruction/data memory; owns the memory write port until the program image is in place.
- Accepts a byte stream (valid/ready) carrying a 16-bit word count followed by little-endian 32-bit words, and writes them to consecutive memory addresses starting at 0.
- Holds the processor via cpu_hold until the load completes, then releases it so execution begins at address 0.

Parameters:
- ADDR_W, 12, memory address width; matches processor program_counter width.
- DATA_W, 32, memory word width; fixed at 32 (4 bytes per word).
- MAX_WORDS, 4096, largest legal word count; must be <= 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts the byte this cycle; transfer = in_valid & in_ready.
- mem_we  output  1  one-cycle memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  DATA_W  write data.
- cpu_hold  output  1  1 = processor stalled and memory port owned by loader.
- busy  output  1  load in progress.
- done  output  1  last load completed successfully.
- err  output  1  last load aborted.

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, done=0, err=0; word index, count and byte counter cleared.
- States: IDLE, LEN0, LEN1, DATA, WRITE, (CSUM with option), DONE, ERROR.
- IDLE/DONE/ERROR: on start, go to LEN0; clear done and err; set busy=1 and cpu_hold=1. In all other states start is ignored.
- LEN0: in_ready=1; on transfer, count[7:0]=byte; go to LEN1.
- LEN1: in_ready=1; on transfer, count[15:8]=byte. Then:
  - count==0: go to DONE.
  - count>MAX_WORDS: go to ERROR.
  - otherwise: go to DATA with index=0 and byte counter=0.
- DATA: in_ready=1; each transfer shifts the byte into word[8*k+:8], k=0..3 (LSB first). When the 4th byte is accepted, go to WRITE.
- WRITE: exactly one cycle with in_ready=0 and mem_we=1, mem_addr=index[ADDR_W-1:0], mem_wdata=assembled word.
  - If index==count-1: go to DONE (or CSUM with the option).
  - Otherwise: index+=1 and return to DATA.
- Write latency: mem_we rises in the cycle after the 4th byte handshake.
- DONE: busy=0, done=1, cpu_hold=0, in_ready=0. Holds until the next start.
- ERROR: busy=0, err=1, cpu_hold=1 (processor stays stalled), in_ready=0, no further writes.
- in_valid without a handshake while in_ready=0 is ignored; bytes are never dropped or duplicated.
- mem_addr and mem_wdata hold their last value when mem_we=0.
- Indexing is bounded by MAX_WORDS, so the address never wraps inside a legal load.
- A stalled stream (in_valid low) leaves the loader waiting indefinitely; there is no timeout.
- rst_n asserted mid-load aborts immediately to the reset values. Memory contents already written are left as they are.
- A start in the same cycle as the final DATA byte is ignored.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR of every data byte (length bytes excluded) is kept.
  - After the final WRITE, enter CSUM with in_ready=1 and accept one byte.
  - Byte equals XOR: go to DONE. Otherwise: go to ERROR.
  - All words have already been written to memory in either case.
- Undefined: no CSUM state; the final WRITE goes straight to DONE and no checksum byte is consumed.

Test Plan:
- Reset then idle 5 cycles -> cpu_hold=1, busy=0, done=0, err=0, in_ready=0, mem_we=0.
- start; bytes 02 00, 78 56 34 12, EF BE AD DE -> mem_we pulses with (addr 0, 0x12345678) then (addr 1, 0xDEADBEEF); done=1, cpu_hold=0, busy=0.
- start; bytes 00 00 -> no mem_we, done=1 two cycles after the second byte handshake.
- start; bytes 01 10 (count 4097) -> err=1, cpu_hold=1, no mem_we; a later start with a valid image completes normally.
- Random in_valid gaps (50%) on a 3-word image; extra start pulses mid-load -> identical writes; starts ignored; in_ready=0 in every WRITE cycle.
- Assert rst_n low after 2 of 4 data bytes -> all outputs take reset values asynchronously; the next load writes from addr 0.
- CHECKSUM_EN: image 01 00, 01 02 04 08, then checksum 0F -> done=1. With checksum 0E instead -> err=1, and word 0x08040201 is still written to addr 0.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-prefixed little-endian word stream and writes it to memory from address 0.
// Optional trailing XOR checksum byte is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module program_loader #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [15:0]         r_count;
    logic [15:0]         r_index;
    logic [1:0]          r_byte_cnt;
    logic [DATA_W-1:0]   r_word;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]          r_csum;
`endif

    logic                w_in_ready;
    logic                w_xfer;
    logic [15:0]         w_len;
    logic                w_last_word;
    logic                w_len_too_big;
    logic [DATA_W-1:0]   w_word_next;

    assign w_xfer        = in_valid & w_in_ready;
    assign w_len         = {in_data, r_count[7:0]};
    assign w_len_too_big = ({1'b0, w_len} > 17'(MAX_WORDS));
    assign w_last_word   = (r_index == (r_count - 16'd1));

    always_comb begin
        w_word_next = r_word;
        w_word_next[{r_byte_cnt, 3'b000} +: 8] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_state_next = S_LEN0;
                end
            end
            S_LEN0: begin
                w_in_ready = 1'b1;
                if (w_xfer) begin
                    w_state_next = S_LEN1;
                end
            end
            S_LEN1: begin
                w_in_ready = 1'b1;
                if (w_xfer) begin
                    if (w_len == 16'd0) begin
                        w_state_next = S_DONE;
                    end else if (w_len_too_big) begin
                        w_state_next = S_ERROR;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                w_in_ready = 1'b1;
                if (w_xfer && (r_byte_cnt == 2'd3)) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    w_state_next = S_CSUM;
`else
                    w_state_next = S_DONE;
`endif
                end else begin
                    w_state_next = S_DATA;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                w_in_ready = 1'b1;
                if (w_xfer) begin
                    w_state_next = (in_data == r_csum) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Address/data are captured on the final byte so they stay stable whenever mem_we is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_index     <= '0;
            r_byte_cnt  <= '0;
            r_word      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_count    <= '0;
                        r_index    <= '0;
                        r_byte_cnt <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                S_LEN0: begin
                    if (w_xfer) begin
                        r_count[7:0] <= in_data;
                    end
                end
                S_LEN1: begin
                    if (w_xfer) begin
                        r_count[15:8] <= in_data;
                        r_index       <= '0;
                        r_byte_cnt    <= '0;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_word     <= w_word_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ in_data;
`endif
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_addr  <= r_index[ADDR_W-1:0];
                            r_mem_wdata <= w_word_next;
                        end
                    end
                end
                S_WRITE: begin
                    if (!w_last_word) begin
                        r_index <= r_index + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign mem_we    = (r_state == S_WRITE);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_ERROR);
    assign cpu_hold  = (r_state != S_DONE);
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; follows PROGRAM_LOADER_CHECKSUM_EN when defined.
`timescale 1ns/1ps
module tb_program_loader;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    program_loader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_WORDS (4096)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_cmp      = 0;
    int n_err      = 0;
    int wr_total   = 0;
    int ready_viol = 0;
    int base;
    logic [ADDR_W-1:0] wr_addr [0:63];
    logic [DATA_W-1:0] wr_data [0:63];

    // Write log, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) begin
            if (wr_total < 64) begin
                wr_addr[wr_total] = mem_addr;
                wr_data[wr_total] = mem_wdata;
            end
            if (in_ready !== 1'b0) ready_viol++;
            wr_total++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        chk({tag, "_addr"}, 64'(wr_addr[idx]), 64'(a));
        chk({tag, "_data"}, 64'(wr_data[idx]), 64'(d));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts and returns on a falling edge; the handshake lands on the rising edge in between.
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int budget;
        budget = 200;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        #1;
        while (in_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        n_cmp++;
        assert (budget > 0) else begin
            n_err++;
            $error("FAIL handshake_timeout: observed no in_ready for byte %0h, required in_ready within 200 cycles", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_pct);
        for (int unsigned k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], gap_pct);
        end
    endtask

    task automatic finish_load(input logic [7:0] csum);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(csum, 0);
`else
        if (csum == 8'hxx) begin end
        @(negedge clk);
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        chk("in_reset_hold", cpu_hold, 1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_hold", cpu_hold, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_err", err, 0);
        chk("idle_ready", in_ready, 0);
        chk("idle_we", mem_we, 0);
        chk("idle_addr", mem_addr, 0);

        // Two-word image, no gaps
        base = wr_total;
        pulse_start();
        chk("t2_busy", busy, 1);
        chk("t2_ready", in_ready, 1);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h12345678, 0);
        chk("t2_we0", mem_we, 1);
        chk("t2_we0_ready", in_ready, 0);
        chk("t2_addr0", mem_addr, 0);
        chk("t2_data0", mem_wdata, 32'h12345678);
        send_word(32'hDEADBEEF, 0);
        chk("t2_we1", mem_we, 1);
        chk("t2_addr1", mem_addr, 1);
        chk("t2_data1", mem_wdata, 32'hDEADBEEF);
        finish_load(8'h2A);
        chk("t2_done", done, 1);
        chk("t2_hold", cpu_hold, 0);
        chk("t2_busy_end", busy, 0);
        chk("t2_we_end", mem_we, 0);
        chk("t2_addr_hold", mem_addr, 1);
        chk("t2_data_hold", mem_wdata, 32'hDEADBEEF);
        chk("t2_nwr", wr_total - base, 2);

        // Zero-length image
        base = wr_total;
        pulse_start();
        chk("t3_done_clr", done, 0);
        chk("t3_hold", cpu_hold, 1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        chk("t3_done", done, 1);
        chk("t3_nwr", wr_total - base, 0);

        // Oversize count 4097
        base = wr_total;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        @(negedge clk);
        chk("t4_err", err, 1);
        chk("t4_hold", cpu_hold, 1);
        chk("t4_busy", busy, 0);
        chk("t4_ready", in_ready, 0);
        chk("t4_nwr", wr_total - base, 0);

        // Recovery after error
        base = wr_total;
        pulse_start();
        chk("t4r_err_clr", err, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'h44332211, 0);
        finish_load(8'h44);
        chk("t4r_done", done, 1);
        chk("t4r_nwr", wr_total - base, 1);
        chk_log("t4r_w0", base, 0, 32'h44332211);

        // Three words with 50% valid gaps and ignored start pulses
        base = wr_total;
        ready_viol = 0;
        pulse_start();
        send_byte(8'h03, 50);
        send_byte(8'h00, 50);
        send_word(32'hA3A2A1A0, 50);
        pulse_start();
        send_byte(8'hB0, 50);
        pulse_start();
        send_byte(8'hB1, 50);
        send_byte(8'hB2, 50);
        send_byte(8'hB3, 50);
        send_byte(8'hC0, 50);
        send_byte(8'hC1, 50);
        send_byte(8'hC2, 50);
        start = 1'b1;
        send_byte(8'hC3, 0);
        start = 1'b0;
        finish_load(8'h00);
        chk("t5_done", done, 1);
        chk("t5_nwr", wr_total - base, 3);
        chk_log("t5_w0", base, 0, 32'hA3A2A1A0);
        chk_log("t5_w1", base + 1, 1, 32'hB3B2B1B0);
        chk_log("t5_w2", base + 2, 2, 32'hC3C2C1C0);
        chk("t5_ready_in_write", ready_viol, 0);

        // Count 4096 is legal; reset asynchronously after two data bytes
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        chk("t6_max_busy", busy, 1);
        chk("t6_max_err", err, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_hold", cpu_hold, 1);
        chk("t6_rst_ready", in_ready, 0);
        chk("t6_rst_we", mem_we, 0);
        chk("t6_rst_addr", mem_addr, 0);
        chk("t6_rst_data", mem_wdata, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = wr_total;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hF0DEBC9A, 0);
        finish_load(8'h08);
        chk("t6_done", done, 1);
        chk("t6_nwr", wr_total - base, 1);
        chk_log("t6_w0", base, 0, 32'hF0DEBC9A);

        // Checksum good / bad (default build: plain single-word load)
        base = wr_total;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'h08040201, 0);
        finish_load(8'h0F);
        chk("t7_done", done, 1);
        chk_log("t7_w0", base, 0, 32'h08040201);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        base = wr_total;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'h08040201, 0);
        send_byte(8'h0E, 0);
        chk("t7_bad_err", err, 1);
        chk("t7_bad_done", done, 0);
        chk("t7_bad_hold", cpu_hold, 1);
        chk("t7_bad_nwr", wr_total - base, 1);
        chk_log("t7_bad_w0", base, 0, 32'h08040201);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
